// File: rtl/spike_delay_pkg.sv
// spike_delay_pkg: shared state type, default sizes and delay-legality rule for the spike delay line
package spike_delay_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

    localparam int DEPTH_DEF = 100;
    localparam int AW_DEF    = 19;
    localparam int DW_DEF    = 8;

    // A delay of DEPTH would read and write the same RAM entry
    function automatic logic delay_ok(input int delay, input int depth);
        return (delay >= 1) && (delay < depth);
    endfunction

endpackage

// File: rtl/spike_delay_ctrl_wrap_ptr.sv
// wrap_ptr: modulo-DEPTH up-counter with enable and synchronous clear
module wrap_ptr #(
    parameter int DEPTH = 100,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i)
            ptr_q <= '0;
        else if (en_i)
            ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/spike_delay_ctrl.sv
// spike_delay_ctrl: pointer/fill sequencer for a 1-bit dual-port BRAM spike delay line.
// Optional SPIKE_DELAY_STATS_EN adds saturating spike in/out counters.
module spike_delay_ctrl import spike_delay_pkg::*; #(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int DELAY_RST = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          spike_in,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_delay,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_din,
    output logic [AW-1:0] ram_raddr,
    input  logic          ram_dout,
    output logic          spike_out,
    output logic          out_valid,
    output logic [DW-1:0] cur_delay
`ifdef SPIKE_DELAY_STATS_EN
    ,
    output logic [15:0]   spikes_in_cnt,
    output logic [15:0]   spikes_out_cnt
`endif
);

    state_e        state_q;
    logic [DW-1:0] cur_delay_q;
    logic [DW-1:0] fill_cnt_q;
    logic          ram_we_q;
    logic          out_valid_q;
    logic          cfg_err_q;
    logic          cfg_ready_q;
    logic          cfg_fire;
    logic          cfg_ok;
    logic [AW-1:0] waddr;
    logic [AW:0]   diff;
    logic [AW:0]   diff_wrap;

    assign cfg_fire = cfg_valid & cfg_ready_q;
    assign cfg_ok   = delay_ok(32'(cfg_delay), DEPTH);

    wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (1'b0),
        .en_i  (ram_we_q),
        .ptr_o (waddr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            cur_delay_q <= DW'(DELAY_RST);
            ram_we_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            cfg_err_q <= cfg_fire & ~cfg_ok;
            if (cfg_fire && cfg_ok)
                cur_delay_q <= cfg_delay;
            if (!enable) begin
                state_q     <= IDLE;
                ram_we_q    <= 1'b0;
                out_valid_q <= 1'b0;
                cfg_ready_q <= 1'b1;
            end else if ((cfg_fire && cfg_ok) || state_q == IDLE) begin
                // Writes keep running across a reconfig; only the window refills
                state_q     <= FILL;
                fill_cnt_q  <= '0;
                ram_we_q    <= 1'b1;
                out_valid_q <= 1'b0;
                cfg_ready_q <= 1'b0;
            end else if (state_q == FILL) begin
                if (fill_cnt_q == cur_delay_q - DW'(1)) begin
                    state_q     <= RUN;
                    out_valid_q <= 1'b1;
                    cfg_ready_q <= 1'b1;
                end else begin
                    fill_cnt_q <= fill_cnt_q + DW'(1);
                end
            end
        end
    end

    assign diff      = {1'b0, waddr} - (AW+1)'(cur_delay_q);
    assign diff_wrap = diff + (AW+1)'(DEPTH);
    assign ram_raddr = diff[AW] ? diff_wrap[AW-1:0] : diff[AW-1:0];

    assign ram_we    = ram_we_q;
    assign ram_waddr = waddr;
    assign ram_din   = spike_in;
    assign spike_out = ram_dout & out_valid_q;
    assign out_valid = out_valid_q;
    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign cur_delay = cur_delay_q;

`ifdef SPIKE_DELAY_STATS_EN
    logic [15:0] in_cnt_q;
    logic [15:0] out_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || (cfg_fire && cfg_ok)) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (spike_in && ram_we_q && !(&in_cnt_q))
                in_cnt_q <= in_cnt_q + 16'd1;
            if (spike_out && !(&out_cnt_q))
                out_cnt_q <= out_cnt_q + 16'd1;
        end
    end

    assign spikes_in_cnt  = in_cnt_q;
    assign spikes_out_cnt = out_cnt_q;
`endif

endmodule

// File: tb/tb_spike_delay_ctrl.sv
// tb_spike_delay_ctrl: directed + random stimulus against a write-history reference model
module tb_spike_delay_ctrl;

    localparam int DEPTH = 100;
    localparam int AW    = 19;
    localparam int DW    = 8;
    localparam int DRST  = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          spike_in = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_delay = '0;
    logic          cfg_ready, cfg_err, ram_we, ram_din, spike_out, out_valid;
    logic          ram_dout = 1'b0;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] cur_delay;
`ifdef SPIKE_DELAY_STATS_EN
    logic [15:0]   spikes_in_cnt, spikes_out_cnt;
`endif

    bit mem [128];

    int errors = 0;
    int checks = 0;

    // Reference model: the output is the sample written `delay` writes ago
    bit m_wr, m_val, m_err, m_acc, m_stats_ok;
    int m_left, m_delay, m_in_cnt, m_out_cnt, exp_out;
    bit hist [$];

    always #5 clk = ~clk;

    spike_delay_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .DELAY_RST(DRST)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .spike_in  (spike_in),
        .cfg_valid (cfg_valid),
        .cfg_delay (cfg_delay),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_din   (ram_din),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout),
        .spike_out (spike_out),
        .out_valid (out_valid),
        .cur_delay (cur_delay)
`ifdef SPIKE_DELAY_STATS_EN
        ,
        .spikes_in_cnt  (spikes_in_cnt),
        .spikes_out_cnt (spikes_out_cnt)
`endif
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr[6:0]] <= ram_din;
        ram_dout <= mem[ram_raddr[6:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ready, legal;
        int n, src;
        ready = !(m_wr && !m_val);
        m_acc = cfg_valid && ready;
        legal = m_acc && int'(cfg_delay) >= 1 && int'(cfg_delay) < DEPTH;
        if (reset) begin
            hist.delete();
            m_wr = 0; m_val = 0; m_err = 0; m_acc = 0; m_delay = DRST;
            m_in_cnt = 0; m_out_cnt = 0; m_stats_ok = 1; exp_out = 0;
        end else begin
            if (exp_out == 1) m_out_cnt++;
            if (exp_out < 0) m_stats_ok = 0;
            n = hist.size();
            src = n - m_delay;
            if (m_wr) begin
                hist.push_back(spike_in);
                if (spike_in) m_in_cnt++;
            end
            m_err = m_acc && !legal;
            if (legal) begin
                m_delay = int'(cfg_delay);
                m_in_cnt = 0; m_out_cnt = 0; m_stats_ok = 1;
            end
            if (!enable) begin
                m_wr = 0; m_val = 0;
            end else if (legal || !m_wr) begin
                m_wr = 1; m_val = 0; m_left = m_delay;
            end else if (!m_val) begin
                m_left--;
                if (m_left == 0) m_val = 1;
            end
            exp_out = !m_val ? 0 : (src >= 0 ? int'(hist[src]) : -1);
        end
    endtask

    task automatic check_all();
        int n;
        n = hist.size();
        chk("ram_we", 32'(ram_we), 32'(m_wr));
        chk("out_valid", 32'(out_valid), 32'(m_val));
        chk("cfg_ready", 32'(cfg_ready), 32'(!(m_wr && !m_val)));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("cur_delay", 32'(cur_delay), 32'(m_delay));
        chk("ram_waddr", 32'(ram_waddr), 32'(n % DEPTH));
        chk("ram_raddr", 32'(ram_raddr), 32'(((n - m_delay) % DEPTH + DEPTH) % DEPTH));
        if (exp_out >= 0) chk("spike_out", 32'(spike_out), 32'(exp_out));
        if (ram_we) chk("no_collision", 32'(ram_raddr != ram_waddr), 32'(1));
`ifdef SPIKE_DELAY_STATS_EN
        if (m_stats_ok) begin
            chk("spikes_in_cnt", 32'(spikes_in_cnt), 32'(m_in_cnt));
            chk("spikes_out_cnt", 32'(spikes_out_cnt), 32'(m_out_cnt));
        end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic rnd_steps(input int n);
        for (int i = 0; i < n; i++) begin
            spike_in = ($urandom_range(3) == 0);
            step();
        end
    endtask

    task automatic cfg_pulse(input int d);
        cfg_delay = DW'(d);
        cfg_valid = 1'b1;
        spike_in = ($urandom_range(3) == 0);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        // Reset values
        step();
        step();
        chk("rst_raddr", 32'(ram_raddr), 32'(95));
        chk("rst_ready", 32'(cfg_ready), 32'(1));
        chk("rst_delay", 32'(cur_delay), 32'(DRST));
        // Basic latency with delay 5
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            spike_in = (i == 20);
            step();
            if (i == 5) chk("t1_not_valid_yet", 32'(out_valid), 32'(0));
            if (i == 6) chk("t1_valid_rise", 32'(out_valid), 32'(1));
            if (i >= 21 && i <= 27) chk("t1_latency", 32'(spike_out), 32'(i == 25));
        end
        // Pointer wrap with periodic spikes
        for (int i = 0; i < 250; i++) begin
            spike_in = (i % 37 == 0);
            step();
        end
        // Illegal configs
        cfg_pulse(0);
        chk("t4_err0", 32'(cfg_err), 32'(1));
        spike_in = 1'b0;
        step();
        chk("t4_err0_single", 32'(cfg_err), 32'(0));
        cfg_pulse(100);
        chk("t4_err100", 32'(cfg_err), 32'(1));
        chk("t4_delay_kept", 32'(cur_delay), 32'(DRST));
        rnd_steps(20);
        // Reconfigure to 40 while running
        cfg_pulse(40);
        chk("t3_valid_drop", 32'(out_valid), 32'(0));
        chk("t3_ready_low", 32'(cfg_ready), 32'(0));
        rnd_steps(100);
        // Boundary delays
        cfg_pulse(1);
        rnd_steps(30);
        cfg_pulse(99);
        rnd_steps(250);
        // Config held through FILL must wait, not drop
        cfg_pulse(50);
        cfg_delay = DW'(7);
        cfg_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 100 && !acc; i++) begin
            spike_in = ($urandom_range(3) == 0);
            step();
            acc = m_acc;
        end
        cfg_valid = 1'b0;
        chk("t5_held_cfg_taken", 32'(cur_delay), 32'(7));
        rnd_steps(40);
        // Random enable/config traffic
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(59) != 0);
            cfg_valid = ($urandom_range(29) == 0);
            cfg_delay = DW'($urandom_range(120));
            spike_in = ($urandom_range(3) == 0);
            step();
        end
        cfg_valid = 1'b0;
        enable = 1'b1;
        rnd_steps(120);
        // Enable drop coinciding with a legal config
        enable = 1'b0;
        cfg_pulse(12);
        chk("t6_we_off", 32'(ram_we), 32'(0));
        chk("t6_valid_off", 32'(out_valid), 32'(0));
        chk("t6_delay_latched", 32'(cur_delay), 32'(12));
        rnd_steps(5);
        enable = 1'b1;
        rnd_steps(6);
        // Reset in the middle of FILL
        reset = 1'b1;
        step();
        chk("t6_rst_we", 32'(ram_we), 32'(0));
        chk("t6_rst_delay", 32'(cur_delay), 32'(DRST));
        reset = 1'b0;
        rnd_steps(30);
        // Ten spikes after a counter-clearing reconfig
        spike_in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        cfg_delay = DW'(5);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            spike_in = (i % 3 == 0);
            step();
        end
        spike_in = 1'b0;
        for (int i = 0; i < 20; i++) step();
`ifdef SPIKE_DELAY_STATS_EN
        chk("t6_stats_in", 32'(spikes_in_cnt), 32'(10));
        chk("t6_stats_out", 32'(spikes_out_cnt), 32'(10));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
